// File: rtl/instr_prefetch.sv
// Instruction prefetch unit: owns the fetch PC, keeps one 32-bit read in flight and
// buffers returned words in a DEPTH-entry FIFO that feeds the core's decode stage.
module instr_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h2000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic [1:0]  dbg_state
);

    localparam int AW = $clog2(DEPTH);

    // Handshakes: a word moves to the core only in a cycle with instr_valid && instr_ready;
    // mem_req is a one-cycle request and mem_rvalid is the single beat answering it.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state;
    logic [63:0]   fetch_pc;
    logic [63:0]   tag_pc;
    logic [AW:0]   count;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [63:0]   pc_mem   [DEPTH];
    logic [31:0]   word_mem [DEPTH];

    logic          credit;
    logic          push;
    logic          pop;
    logic [AW+1:0] inflight;
    logic          unused_rpc_bits;

    // The outstanding request owns a slot so its beat can always be pushed.
    assign inflight = {1'b0, count} + {{(AW + 1){1'b0}}, (state == WAIT)};
    assign credit   = inflight < (AW + 2)'(DEPTH);

    assign mem_req  = !reset && !redirect && credit &&
                      (state == IDLE || (state == WAIT && mem_rvalid));
    assign mem_addr = fetch_pc;

    assign push = (state == WAIT) && mem_rvalid && !redirect;
    assign pop  = instr_valid && instr_ready && !redirect;

    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? word_mem[rd_ptr] : 32'h0;
    assign instr_pc    = instr_valid ? pc_mem[rd_ptr]   : 64'h0;
    assign dbg_state   = state;

    assign unused_rpc_bits = ^redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= tag_pc;
            word_mem[wr_ptr] <= mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            tag_pc   <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (redirect) begin
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fetch_pc <= {redirect_pc[63:2], 2'b00};
            // A request still in flight becomes stale; its beat must be swallowed in DRAIN.
            if (state == WAIT) begin
                state <= mem_rvalid ? IDLE : DRAIN;
            end else if (state == DRAIN && mem_rvalid) begin
                state <= IDLE;
            end
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (mem_req) begin
                fetch_pc <= fetch_pc + 64'd4;
                tag_pc   <= fetch_pc;
                state    <= WAIT;
            end else if (mem_rvalid && state != IDLE) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_instr_prefetch.sv
// Bench for instr_prefetch: a latency-programmable memory responder, a queue-based
// reference model of the prefetcher, a directed vector table and randomized traffic.
module tb_instr_prefetch;

    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h2000;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic [1:0]  dbg_state;

    instr_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // memory responder
    int          lat = 1;
    bit          pend;
    logic [63:0] pend_addr;
    int          pend_left;

    // reference model: fetch pc, outstanding-request flags and scoreboard queues
    logic [63:0] exp_q   [$];
    logic [31:0] exp_w_q [$];
    logic [63:0] m_pc;
    logic [63:0] m_tag;
    bit          m_live;
    bit          m_stale;
    bit          exp_req;

    typedef struct {
        bit          rst;
        bit          ready;
        bit          exp_req;
        logic [63:0] exp_addr;
        bit          exp_valid;
        logic [63:0] exp_pc;
    } vec_t;

    vec_t vt [15];

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mem_step();
        if (pend && pend_left == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word(pend_addr);
            pend       = 1'b0;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            if (pend) pend_left--;
        end
    endtask

    task automatic model_reset();
        m_pc    = RESET_PC;
        m_tag   = '0;
        m_live  = 1'b0;
        m_stale = 1'b0;
        exp_q.delete();
        exp_w_q.delete();
    endtask

    task automatic cycle_begin();
        mem_step();
        #1;
        exp_req = !redirect && !m_stale && (exp_q.size() + int'(m_live)) < DEPTH &&
                  (!m_live || mem_rvalid);
        chk("mem_req", mem_req, exp_req);
        chk("mem_addr", mem_addr, m_pc);
        chk("instr_valid", instr_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            chk("instr_pc", instr_pc, exp_q[0]);
            chk("instr", instr, exp_w_q[0]);
            chk("instr_vs_mem", instr, mem_word(instr_pc));
        end else begin
            chk("instr_pc_empty", instr_pc, 64'h0);
            chk("instr_empty", instr, 64'h0);
        end
    endtask

    task automatic cycle_end();
        if (redirect) begin
            exp_q.delete();
            exp_w_q.delete();
            m_pc = {redirect_pc[63:2], 2'b00};
            if (m_live) begin
                m_live  = 1'b0;
                m_stale = !mem_rvalid;
            end else if (m_stale && mem_rvalid) begin
                m_stale = 1'b0;
            end
        end else begin
            if (exp_q.size() != 0 && instr_ready) begin
                void'(exp_q.pop_front());
                void'(exp_w_q.pop_front());
            end
            if (m_live && mem_rvalid) begin
                exp_q.push_back(m_tag);
                exp_w_q.push_back(mem_rdata);
                m_live = 1'b0;
            end
            if (m_stale && mem_rvalid) m_stale = 1'b0;
            if (exp_req) begin
                m_tag  = m_pc;
                m_pc   = m_pc + 64'd4;
                m_live = 1'b1;
            end
        end
        if (mem_req) begin
            chk("one_outstanding", pend, 1'b0);
            pend      = 1'b1;
            pend_addr = mem_addr;
            pend_left = lat - 1;
        end
        @(negedge clk);
    endtask

    task automatic step();
        cycle_begin();
        cycle_end();
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        redirect    = 1'b0;
        instr_ready = 1'b0;
        mem_rvalid  = 1'b0;
        pend        = 1'b0;
        #1;
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, RESET_PC);
        chk("rst_instr_valid", instr_valid, 1'b0);
        chk("rst_instr", instr, 64'h0);
        chk("rst_instr_pc", instr_pc, 64'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic wait_valid(input logic [63:0] pc, input string name);
        bit found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cycle_begin();
            if (instr_valid) begin
                chk(name, instr_pc, pc);
                found = 1'b1;
            end
            cycle_end();
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: instr_valid never rose, required within 20 cycles", name);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // streaming with ready=1, then backpressure with ready=0, both on a 1-cycle memory
        vt[0]  = '{1'b1, 1'b1, 1'b1, 64'h2000, 1'b0, 64'h0};
        vt[1]  = '{1'b0, 1'b1, 1'b1, 64'h2004, 1'b0, 64'h0};
        vt[2]  = '{1'b0, 1'b1, 1'b1, 64'h2008, 1'b1, 64'h2000};
        vt[3]  = '{1'b0, 1'b1, 1'b1, 64'h200C, 1'b1, 64'h2004};
        vt[4]  = '{1'b0, 1'b1, 1'b1, 64'h2010, 1'b1, 64'h2008};
        vt[5]  = '{1'b1, 1'b0, 1'b1, 64'h2000, 1'b0, 64'h0};
        vt[6]  = '{1'b0, 1'b0, 1'b1, 64'h2004, 1'b0, 64'h0};
        vt[7]  = '{1'b0, 1'b0, 1'b1, 64'h2008, 1'b1, 64'h2000};
        vt[8]  = '{1'b0, 1'b0, 1'b1, 64'h200C, 1'b1, 64'h2000};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 64'h2010, 1'b1, 64'h2000};
        vt[10] = '{1'b0, 1'b0, 1'b0, 64'h2010, 1'b1, 64'h2000};
        vt[11] = '{1'b0, 1'b1, 1'b0, 64'h2010, 1'b1, 64'h2000};
        vt[12] = '{1'b0, 1'b0, 1'b1, 64'h2010, 1'b1, 64'h2004};
        vt[13] = '{1'b0, 1'b0, 1'b0, 64'h2014, 1'b1, 64'h2004};
        vt[14] = '{1'b0, 1'b0, 1'b0, 64'h2014, 1'b1, 64'h2004};

        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        pend        = 1'b0;
        model_reset();
        @(negedge clk);

        lat = 1;
        for (int i = 0; i < 15; i++) begin
            if (vt[i].rst) do_reset();
            redirect    = 1'b0;
            instr_ready = vt[i].ready;
            cycle_begin();
            chk($sformatf("tbl%0d_req", i), mem_req, vt[i].exp_req);
            chk($sformatf("tbl%0d_addr", i), mem_addr, vt[i].exp_addr);
            chk($sformatf("tbl%0d_valid", i), instr_valid, vt[i].exp_valid);
            chk($sformatf("tbl%0d_pc", i), instr_pc, vt[i].exp_pc);
            cycle_end();
        end
        instr_ready = 1'b1;
        repeat (12) step();

        // redirect while a 3-cycle read is outstanding
        lat = 3;
        do_reset();
        instr_ready = 1'b1;
        step();
        redirect    = 1'b1;
        redirect_pc = 64'h3002;
        cycle_begin();
        chk("rdp_noreq", mem_req, 1'b0);
        cycle_end();
        redirect = 1'b0;
        step();
        cycle_begin();
        chk("rdp_drain_noreq", mem_req, 1'b0);
        cycle_end();
        cycle_begin();
        chk("rdp_req", mem_req, 1'b1);
        chk("rdp_addr", mem_addr, 64'h3000);
        cycle_end();
        wait_valid(64'h3000, "rdp_first_pc");

        // redirect coincident with a response beat and a consume
        lat = 1;
        do_reset();
        step();
        step();
        redirect    = 1'b1;
        redirect_pc = 64'h4000;
        instr_ready = 1'b1;
        cycle_begin();
        chk("coinc_valid_before", instr_valid, 1'b1);
        chk("coinc_noreq", mem_req, 1'b0);
        cycle_end();
        redirect = 1'b0;
        cycle_begin();
        chk("coinc_flushed", instr_valid, 1'b0);
        chk("coinc_req", mem_req, 1'b1);
        chk("coinc_addr", mem_addr, 64'h4000);
        cycle_end();
        repeat (4) step();

        // fetch pc wraps past the top of the address space
        do_reset();
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        cycle_begin();
        chk("wrap_noreq", mem_req, 1'b0);
        cycle_end();
        redirect = 1'b0;
        cycle_begin();
        chk("wrap_addr_top", mem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        cycle_end();
        cycle_begin();
        chk("wrap_req0", mem_req, 1'b1);
        chk("wrap_addr0", mem_addr, 64'h0);
        cycle_end();
        cycle_begin();
        chk("wrap_pc_top", instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        cycle_end();
        cycle_begin();
        chk("wrap_pc0", instr_pc, 64'h0);
        cycle_end();
        repeat (4) step();

        // asynchronous reset while a slow read is outstanding
        lat = 1;
        do_reset();
        step();
        step();
        lat = 3;
        step();
        step();
        mem_step();
        #2;
        reset = 1'b1;
        #1;
        chk("asy_req", mem_req, 1'b0);
        chk("asy_addr", mem_addr, RESET_PC);
        chk("asy_valid", instr_valid, 1'b0);
        chk("asy_instr", instr, 64'h0);
        chk("asy_pc", instr_pc, 64'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        cycle_begin();
        chk("asy_restart_req", mem_req, 1'b1);
        chk("asy_restart_addr", mem_addr, 64'h2000);
        cycle_end();
        wait_valid(64'h2000, "asy_first_pc");

        // randomized traffic across memory latencies
        for (int ph = 0; ph < 3; ph++) begin
            lat = ph + 1;
            do_reset();
            for (int i = 0; i < 400; i++) begin
                instr_ready = ($urandom_range(0, 3) != 0);
                redirect    = ($urandom_range(0, 19) == 0);
                redirect_pc = ($urandom_range(0, 7) == 0) ?
                              64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15)) :
                              {32'h0, $urandom};
                step();
            end
        end
        redirect = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
